// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: sequences MEM-stage loads/stores (word, half, byte) onto a
// word-only single-port synchronous data RAM. Sub-word stores use a
// read-modify-write cycle. Sub-word loads are lane-selected and extended.
// Optional build macro: SUBWORD_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word requests complete at once with misalign=1 and make
// no RAM access.
module subword_mem_ctrl #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  bunsigned,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ack,
  output logic                  stall,
  output logic                  misalign,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned LW = DEPTH_LOG2 + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RESP = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          bunsigned_q;
  logic [LW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ack_q;
  logic          mem_we_q;
  logic          trap_c;
  logic          in_word_c;
  logic [31:0]   load_c;
  logic [15:0]   half_c;
  logic [7:0]    byte_c;
  logic          unused_addr_hi;

  // Address bits above the RAM window do not select a word.
  assign unused_addr_hi = ^addr[AW-1:LW];

  // Sizes 00 and 11 both mean a full word.
  assign in_word_c = (size == 2'b00) || (size == 2'b11);

`ifdef SUBWORD_MISALIGN_TRAP_EN
  logic misalign_q;

  // Misaligned half/word request seen in IDLE.
  assign trap_c = (state_q == IDLE) && req &&
                  (((size == 2'b01) && addr[0]) || (in_word_c && (addr[1:0] != 2'b00)));

  // Misaligned flag pulses with the ack of the rejected request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= trap_c;
    end
  end

  assign misalign = misalign_q;
`else
  assign trap_c   = 1'b0;
  assign misalign = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trap_c) begin
          state_d = DONE;
        end else if (req) begin
          state_d = (we && in_word_c) ? WR : RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      RESP:    state_d = DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      bunsigned_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else if ((state_q == IDLE) && req) begin
      we_q        <= we;
      size_q      <= size;
      bunsigned_q <= bunsigned;
      addr_q      <= addr[LW-1:0];
      wdata_q     <= wdata;
    end
  end

  // Load lane select and sign/zero extension of the RAM word.
  always_comb begin
    half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_c = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   byte_c = mem_rdata[15:8];
      2'b10:   byte_c = mem_rdata[23:16];
      2'b11:   byte_c = mem_rdata[31:24];
      default: byte_c = mem_rdata[7:0];
    endcase
    load_c = mem_rdata;
    case (size_q)
      2'b01:   load_c = {{16{~bunsigned_q & half_c[15]}}, half_c};
      2'b10:   load_c = {{24{~bunsigned_q & byte_c[7]}}, byte_c};
      default: load_c = mem_rdata;
    endcase
  end

  // Store word: full word, or the read word with one lane replaced.
  always_comb begin
    mem_wdata = wdata_q;
    case (size_q)
      2'b01: begin
        mem_wdata = addr_q[1] ? {wdata_q[15:0], mem_rdata[15:0]}
                              : {mem_rdata[31:16], wdata_q[15:0]};
      end
      2'b10: begin
        case (addr_q[1:0])
          2'b01:   mem_wdata = {mem_rdata[31:16], wdata_q[7:0], mem_rdata[7:0]};
          2'b10:   mem_wdata = {mem_rdata[31:24], wdata_q[7:0], mem_rdata[15:0]};
          2'b11:   mem_wdata = {wdata_q[7:0], mem_rdata[23:0]};
          default: mem_wdata = {mem_rdata[31:8], wdata_q[7:0]};
        endcase
      end
      default: mem_wdata = wdata_q;
    endcase
  end

  // Registered handshake, write enable and load result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q    <= 1'b0;
      mem_we_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= (state_d == DONE);
      mem_we_q <= (state_d == WR);
      if (state_q == RESP) begin
        rdata_q <= load_c;
      end else if (trap_c) begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = addr_q[LW-1:2];
  assign stall    = req & (state_q != DONE);

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Bench for subword_mem_ctrl: synchronous RAM model plus a byte-mask reference
// model of memory contents, load results and per-access stall counts.
module tb_subword_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        bunsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;
  logic        misalign;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic        tb_wr_en;
  logic [5:0]  tb_wr_addr;
  logic [31:0] tb_wr_data;
  int unsigned wr_count = 0;
  logic [5:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subword_mem_ctrl #(.AW(32), .DEPTH_LOG2(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .bunsigned (bunsigned),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .stall     (stall),
    .misalign  (misalign),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Single-port synchronous RAM, read-first, with a backdoor preload port.
  always @(posedge clk) begin
    if (tb_wr_en) begin
      ram[tb_wr_addr] <= tb_wr_data;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_word(input logic [1:0] sz);
    return (sz == 2'd0) || (sz == 2'd3);
  endfunction

  function automatic bit ref_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef SUBWORD_MISALIGN_TRAP_EN
    return ((sz == 2'd1) && (a % 2 != 0)) || (is_word(sz) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_shift(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return 8 * int'(a % 4);
    if (sz == 2'd1) return 16 * int'((a / 2) % 2);
    return 0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return 32'h0000_00FF << lane_shift(sz, a);
    if (sz == 2'd1) return 32'h0000_FFFF << lane_shift(sz, a);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] m;
    logic [31:0] sign_bit;
    v = word >> lane_shift(sz, a);
    m = lane_mask(sz, 32'd0);
    if (is_word(sz)) return word;
    v = v & m;
    sign_bit = (m + 1) >> 1;
    if (!u && ((v & sign_bit) != 0)) v = v | ~m;
    return v;
  endfunction

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    tb_wr_en   = 1'b1;
    tb_wr_addr = 6'(idx);
    tb_wr_data = data;
    @(negedge clk);
    tb_wr_en     = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd, input logic drop,
                            output logic [31:0] got);
    int          idx;
    int          exp_stalls;
    int          stalls;
    int          n;
    bit          done;
    bit          trap;
    int unsigned wr0;
    logic [31:0] exp_word;
    idx  = int'((a / 4) % 64);
    trap = ref_trap(sz, a);
    if (trap || drop)           exp_stalls = 1;
    else if (w && is_word(sz))  exp_stalls = 2;
    else                        exp_stalls = 3;
    wr0 = wr_count;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; bunsigned = u; addr = a; wdata = wd;
    #1;
    stalls = 0; n = 0; done = 1'b0;
    while (!done && n < 20) begin
      if (ack) begin
        done = 1'b1;
      end else begin
        if (stall) stalls++;
        n++;
        @(negedge clk);
        if (drop) req = 1'b0;
        #1;
      end
    end
    if (!done) check32("ack_timeout", 32'd0, 32'd1);
    got = rdata;
    check32("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check32("misalign", 32'(misalign), 32'(trap));
    if (trap) begin
      check32("trap_rdata", rdata, 32'd0);
      check32("trap_writes", wr_count - wr0, 32'd0);
    end else if (w) begin
      exp_word = (ref_mem[idx] & ~lane_mask(sz, a)) | ((wd << lane_shift(sz, a)) & lane_mask(sz, a));
      ref_mem[idx] = exp_word;
      check32("store_writes", wr_count - wr0, 32'd1);
      check32("store_addr", 32'(last_wr_addr), 32'(idx));
      check32("store_data", last_wr_data, exp_word);
    end else begin
      check32("load_rdata", rdata, ref_load(ref_mem[idx], sz, u, a));
      check32("load_writes", wr_count - wr0, 32'd0);
    end
    check32("ram_word", ram[idx], ref_mem[idx]);
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int unsigned w0;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; bunsigned = 1'b0;
    addr = '0; wdata = '0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check32("rst_ack", 32'(ack), 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    check32("rst_misalign", 32'(misalign), 32'd0);
    check32("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);

    // Directed accesses on word 20 (byte address 80).
    run_access(1'b1, 2'd0, 1'b0, 32'd80, 32'h1234_5678, 1'b0, got);
    check32("sw_word", ram[20], 32'h1234_5678);
    poke(20, 32'hAABB_CCDD);
    run_access(1'b1, 2'd2, 1'b0, 32'd81, 32'h1234_56FA, 1'b0, got);
    check32("sb_word", ram[20], 32'hAABB_FADD);
    poke(20, 32'h0000_FA00);
    run_access(1'b0, 2'd2, 1'b0, 32'd81, 32'd0, 1'b0, got);
    check32("lb81", got, 32'hFFFF_FFFA);
    run_access(1'b0, 2'd2, 1'b1, 32'd81, 32'd0, 1'b0, got);
    check32("lbu81", got, 32'h0000_00FA);
    poke(20, 32'h8001_7FFF);
    run_access(1'b0, 2'd1, 1'b0, 32'd82, 32'd0, 1'b0, got);
    check32("lh82", got, 32'hFFFF_8001);
    run_access(1'b0, 2'd1, 1'b1, 32'd82, 32'd0, 1'b0, got);
    check32("lhu82", got, 32'h0000_8001);
    run_access(1'b0, 2'd1, 1'b0, 32'd80, 32'd0, 1'b0, got);
    check32("lh80", got, 32'h0000_7FFF);
    run_access(1'b0, 2'd1, 1'b0, 32'd81, 32'd0, 1'b0, got);
`ifdef SUBWORD_MISALIGN_TRAP_EN
    check32("lh81_trap", got, 32'd0);
`else
    check32("lh81_lane0", got, 32'h0000_7FFF);
`endif
    // Wrap-around word address and dropped req still completing the write.
    poke(5, 32'd0);
    run_access(1'b1, 2'd1, 1'b0, 32'h0000_0116, 32'h0000_BEEF, 1'b1, got);
    check32("drop_sh", ram[5], 32'hBEEF_0000);

    // Reset during the read phase of a byte RMW aborts the write.
    poke(20, 32'hAABB_CCDD);
    run_access(1'b0, 2'd0, 1'b0, 32'd80, 32'd0, 1'b0, got);
    check32("pre_rst_lw", got, 32'hAABB_CCDD);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; bunsigned = 1'b0; addr = 32'd81; wdata = 32'h11;
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_count;
    @(negedge clk);
    #1;
    check32("rmw_rst_mem_we", 32'(mem_we), 32'd0);
    check32("rmw_rst_ack", 32'(ack), 32'd0);
    check32("rmw_rst_rdata", rdata, 32'd0);
    req = 1'b0;
    @(negedge clk);
    #1;
    check32("rmw_rst_mem_we2", 32'(mem_we), 32'd0);
    check32("rmw_rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check32("rmw_rst_writes", wr_count - w0, 32'd0);
    check32("rmw_rst_ram", ram[20], 32'hAABB_CCDD);

    // Randomized back-to-back traffic.
    for (int k = 0; k < 150; k++) begin
      run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, ($urandom_range(0, 7) == 0), got);
    end
    @(negedge clk);
    #1;
    check32("final_ack", 32'(ack), 32'd0);
    check32("final_mem_we", 32'(mem_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
